// File: rtl/hkspi_pkg.sv
// Shared definitions for the housekeeping SPI slave: FSM states and command field layout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hkspi_pkg;

    // Frame phases, kept as plain constants so older tools read them unchanged.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    // Command byte: [7:6] access type, [5:3] byte count (0 = stream), [2:0] must be zero.
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_RW    = 2'b11;
    localparam int         CMD_NBYTES_LSB = 3;

    // SCK high and low phases must each last at least this many core clocks.
    localparam int SCK_MIN_PHASE = 4;

    // A command is accepted only with a non-zero access type and clear reserved bits.
    function automatic logic cmd_ok(input logic [7:0] cmd);
        return (cmd[7:6] != 2'b00) && (cmd[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/hkspi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pad input, plus rise/fall pulse detection.
// Latency: STAGES clocks from pad to level; edge pulses appear in the first cycle of the new level.
// Backpressure: none; free-running sampler.
module hkspi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock_i,
    input  logic resetb_i,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pad value through the synchroniser and remember the last settled level.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/hkspi_slave_sync.sv
// Housekeeping SPI slave: oversamples pad SCK/CSB/SDI and turns command/address/data frames into register strobes.
// Latency: strobes a few clocks after the synchronised 8th SCK rise; read data reaches sdo before the next SCK rise.
// Backpressure: none; the register bank takes reg_we/reg_rd any cycle and returns reg_rdata the cycle after reg_rd.
module hkspi_slave_sync
    import hkspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata
);

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic csb_s, csb_rise, csb_fall;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;

    hkspi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .clock_i(clock), .resetb_i(resetb), .d_i(sck),
        .lvl_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    // The csb chain resets low, so a frame can only start from a csb fall seen after reset.
    hkspi_sync_edge #(.STAGES(SYNC_STAGES)) u_csb (
        .clock_i(clock), .resetb_i(resetb), .d_i(csb),
        .lvl_o(csb_s), .rise_o(csb_rise), .fall_o(csb_fall)
    );
    hkspi_sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (
        .clock_i(clock), .resetb_i(resetb), .d_i(sdi),
        .lvl_o(sdi_s), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] in_sr_q, in_sr_d;
    logic       rd_mode_q, rd_mode_d, wr_mode_q, wr_mode_d;
    logic [2:0] nbytes_q, nbytes_d, byte_cnt_q, byte_cnt_d;
    logic [7:0] reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d, reg_rd_q, reg_rd_d;
    logic       inc_q, inc_d, ld_q, ld_d;
    logic [7:0] out_sr_q, out_sr_d;

    logic       byte_done;
    logic [7:0] byte_val;
    logic       in_frame;

    assign byte_done = sck_rise && (cnt_q == 3'd7);
    assign byte_val  = {in_sr_q, sdi_s};
    assign in_frame  = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

    // Frame decode, strobe generation and sdo shifting.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_sr_d     = in_sr_q;
        rd_mode_d   = rd_mode_q;
        wr_mode_d   = wr_mode_q;
        nbytes_d    = nbytes_q;
        byte_cnt_d  = byte_cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        out_sr_d    = out_sr_q;
        reg_we_d    = 1'b0;
        reg_rd_d    = 1'b0;
        inc_d       = 1'b0;
        ld_d        = reg_rd_q;

        // After a data byte the write strobe goes out first, then the address steps, then the next byte is prefetched.
        if (inc_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
            reg_rd_d   = rd_mode_q;
        end

        // The fall that ends a byte (count back at 0) must not shift: the prefetch load supplies the next MSB.
        if (ld_q) begin
            out_sr_d = reg_rdata;
        end else if (sck_fall && (state_q == ST_DATA) && (cnt_q != 3'd0)) begin
            out_sr_d = {out_sr_q[6:0], 1'b0};
        end

        if (csb_rise) begin
            // Deselect wins over everything, including a byte completing in the same cycle.
            state_d    = ST_IDLE;
            cnt_d      = 3'd0;
            reg_addr_d = reg_addr_q;
            reg_rd_d   = 1'b0;
            ld_d       = 1'b0;
        end else begin
            if (sck_rise && in_frame) begin
                cnt_d   = cnt_q + 3'd1;
                in_sr_d = {in_sr_q[5:0], sdi_s};
            end
            case (state_q)
                ST_IDLE: begin
                    if (csb_fall) begin
                        state_d = ST_CMD;
                        cnt_d   = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        wr_mode_d = (byte_val[7:6] == CMD_WRITE) || (byte_val[7:6] == CMD_RW);
                        rd_mode_d = (byte_val[7:6] == CMD_READ) || (byte_val[7:6] == CMD_RW);
                        nbytes_d  = byte_val[CMD_NBYTES_LSB +: 3];
                        state_d   = cmd_ok(byte_val) ? ST_ADDR : ST_HOLD;
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        reg_addr_d = byte_val;
                        reg_rd_d   = rd_mode_q;
                        byte_cnt_d = 3'd0;
                        state_d    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        if (wr_mode_q) begin
                            reg_wdata_d = byte_val;
                            reg_we_d    = 1'b1;
                        end
                        inc_d      = 1'b1;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if ((nbytes_q != 3'd0) && ((byte_cnt_q + 3'd1) == nbytes_q)) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            in_sr_q     <= 7'd0;
            rd_mode_q   <= 1'b0;
            wr_mode_q   <= 1'b0;
            nbytes_q    <= 3'd0;
            byte_cnt_q  <= 3'd0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            inc_q       <= 1'b0;
            ld_q        <= 1'b0;
            out_sr_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_sr_q     <= in_sr_d;
            rd_mode_q   <= rd_mode_d;
            wr_mode_q   <= wr_mode_d;
            nbytes_q    <= nbytes_d;
            byte_cnt_q  <= byte_cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_rd_q    <= reg_rd_d;
            inc_q       <= inc_d;
            ld_q        <= ld_d;
            out_sr_q    <= out_sr_d;
        end
    end

    assign sdo_oe    = (state_q == ST_DATA) && rd_mode_q && !csb_s;
    assign sdo       = sdo_oe & out_sr_q[7];
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_rd    = reg_rd_q;

endmodule

// File: tb/tb_hkspi_slave_sync.sv
// Bench for the housekeeping SPI slave: SPI master stimulus, register-file ROM model, strobe scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_hkspi_slave_sync;
    import hkspi_pkg::*;

    localparam int CLK_PER = 20;
    localparam int HALF    = (SCK_MIN_PHASE + 1) * CLK_PER;

    logic       clock, resetb, sck, csb, sdi;
    logic       sdo, sdo_oe, reg_we, reg_rd;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    hkspi_slave_sync #(.SYNC_STAGES(2)) dut (
        .clock(clock), .resetb(resetb), .sck(sck), .csb(csb), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_rd(reg_rd), .reg_rdata(reg_rdata)
    );

    typedef struct packed {
        logic       is_we;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] rom [0:255];
    logic [7:0] tx_d [0:31];
    logic [7:0] rx_d [0:31];
    int         total = 0;
    int         bad   = 0;

    initial begin
        clock = 1'b0;
        forever #(CLK_PER / 2) clock = ~clock;
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Register bank model: read-only contents, data valid for the cycle after reg_rd, junk otherwise.
    initial begin
        logic held;
        held      = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clock);
            if (reg_rd) begin
                reg_rdata = rom[reg_addr];
                held      = 1'b1;
            end else if (held) begin
                held = 1'b0;
            end else begin
                reg_rdata = 8'($urandom);
            end
        end
    end

    // Strobe monitor: every reg_we/reg_rd must match the next expected event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if (reg_we && reg_rd) begin
                total++;
                bad++;
                $display("FAIL we_rd_overlap: got both strobes at addr %02h, required at most one", reg_addr);
            end else if (reg_we || reg_rd) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got we=%0b rd=%0b addr=%02h data=%02h, required none",
                             reg_we, reg_rd, reg_addr, reg_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check8("strobe_kind_we", {7'd0, reg_we}, {7'd0, e.is_we});
                    check8("strobe_addr", reg_addr, e.addr);
                    if (e.is_we) check8("strobe_wdata", reg_wdata, e.data);
                end
            end
        end
    end

    // One SPI mode-0 byte (or fewer bits): sdi set while SCK low, sdo sampled at SCK rise.
    task automatic spi_byte(input logic [7:0] b, input int nbits, input logic oe_exp, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sdi = b[7-i];
            #(HALF);
            sck = 1'b1;
            r = {r[6:0], sdo};
            check8("sdo_oe_bit", {7'd0, sdo_oe}, {7'd0, oe_exp});
            #(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check8({tag, "_sdo"}, {7'd0, sdo}, 8'h00);
        check8({tag, "_sdo_oe"}, {7'd0, sdo_oe}, 8'h00);
        check8({tag, "_reg_addr"}, reg_addr, 8'h00);
        check8({tag, "_reg_wdata"}, reg_wdata, 8'h00);
        check8({tag, "_reg_we"}, {7'd0, reg_we}, 8'h00);
        check8({tag, "_reg_rd"}, {7'd0, reg_rd}, 8'h00);
    endtask

    // Full frame: command, address, nsend data bytes from tx_d (last one may be cut short).
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int nsend, input int last_bits);
        logic       wr, rd, valid, oe_exp;
        int         n, nfull, nproc, bits;
        logic [7:0] r, a;
        wr    = cmd[7];
        rd    = cmd[6];
        valid = (cmd[7:6] != 2'b00) && (cmd[2:0] == 3'b000);
        n     = int'(cmd[5:3]);
        nfull = (last_bits == 8) ? nsend : nsend - 1;
        nproc = !valid ? 0 : ((n == 0) || (nfull < n)) ? nfull : n;
        if (valid && rd) exp_q.push_back({1'b0, addr, 8'h00});
        for (int i = 0; i < nproc; i++) begin
            a = addr + 8'(i);
            if (wr) exp_q.push_back({1'b1, a, tx_d[i]});
            if (rd) exp_q.push_back({1'b0, a + 8'd1, 8'h00});
        end
        csb = 1'b0;
        #(2 * HALF);
        spi_byte(cmd, 8, 1'b0, r);
        spi_byte(addr, 8, 1'b0, r);
        for (int i = 0; i < nsend; i++) begin
            bits   = (i == nsend - 1) ? last_bits : 8;
            oe_exp = valid && rd && ((n == 0) || (i < n));
            spi_byte(tx_d[i], bits, oe_exp, r);
            rx_d[i] = r;
        end
        #(HALF);
        csb = 1'b1;
        #(3 * HALF);
        if (rd && valid) begin
            for (int i = 0; i < nproc; i++) check8("sdo_byte", rx_d[i], rom[addr + 8'(i)]);
        end
        check8("after_frame_sdo_oe", {7'd0, sdo_oe}, 8'h00);
        check8("strobes_outstanding", 8'(exp_q.size()), 8'h00);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] r;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h00; rom[1] = 8'h04; rom[2] = 8'h56; rom[3] = 8'h11; rom[18] = 8'h04;
        for (int i = 0; i < 32; i++) tx_d[i] = 8'h00;
        resetb = 1'b0; csb = 1'b1; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        resetb = 1'b1;
        #(4 * CLK_PER);

        // Single-byte read of 0x03.
        run_frame(8'h40, 8'h03, 1, 8);
        // Single-byte writes to 0x0B.
        tx_d[0] = 8'h01;
        run_frame(8'h80, 8'h0B, 1, 8);
        tx_d[0] = 8'h00;
        run_frame(8'h80, 8'h0B, 1, 8);
        // Stream read of 19 bytes from 0x00.
        for (int i = 0; i < 19; i++) tx_d[i] = 8'h00;
        run_frame(8'h40, 8'h00, 19, 8);
        // Fixed one-byte write: the second byte lands in HOLD.
        tx_d[0] = 8'h55; tx_d[1] = 8'hAA;
        run_frame(8'h88, 8'h07, 2, 8);
        // Stream write wrapping 0xFF -> 0x00.
        tx_d[0] = 8'($urandom); tx_d[1] = 8'($urandom);
        run_frame(8'h80, 8'hFF, 2, 8);
        // Abort after 5 bits of a write byte, then a normal read.
        tx_d[0] = 8'hC3;
        run_frame(8'h80, 8'h20, 1, 5);
        tx_d[0] = 8'h00;
        run_frame(8'h40, 8'h03, 1, 8);

        // Reset pulsed in the middle of the address byte, csb still low afterwards.
        csb = 1'b0;
        #(2 * HALF);
        spi_byte(8'h40, 8, 1'b0, r);
        spi_byte(8'h12, 4, 1'b0, r);
        resetb = 1'b0;
        #(2 * CLK_PER);
        check_idle_outputs("midaddr_reset");
        resetb = 1'b1;
        #(2 * CLK_PER);
        check_idle_outputs("after_reset");
        spi_byte(8'hFF, 8, 1'b0, r);
        spi_byte(8'hFF, 8, 1'b0, r);
        csb = 1'b1;
        #(3 * HALF);
        check8("reset_strobes_outstanding", 8'(exp_q.size()), 8'h00);
        tx_d[0] = 8'h00;
        run_frame(8'h40, 8'h03, 1, 8);

        // Randomised frames: all access types, stream and fixed counts, one reserved-bit command.
        for (int it = 0; it < 8; it++) begin
            logic [1:0] mode;
            logic [2:0] nb;
            logic [7:0] cmd;
            int         nsend;
            mode  = 2'($urandom_range(1, 3));
            nb    = 3'($urandom_range(0, 3));
            cmd   = {mode, nb, (it == 2) ? 3'b101 : 3'b000};
            nsend = $urandom_range(1, 4);
            for (int i = 0; i < nsend; i++) tx_d[i] = 8'($urandom);
            run_frame(cmd, 8'($urandom), nsend, 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
